decode_stage: RTL and testbench

- Parametrised, pipelined RV32/RV64 instruction decode stage. Sits between fetch and execute.
- Decodes one instruction per cycle into control signals and a sign-extended immediate. Adds LUI/AUIPC, RV64 W-ops, optional M extension and illegal-instruction flagging.
- Registers all results behind a valid/ready handshake with a 2-entry skid buffer, so ready_o is a registered signal. Supports pipeline flush.

---
 rtl/decode_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// riscv_pkg: shared opcode constants and the decoded-operation enums used
// between decode and execute.
//
// decode_stage: pipelined RV32/RV64 instruction decode. One instruction per
// cycle is decoded into control signals and a sign-extended immediate, then
// registered behind a valid/ready handshake with a 2-entry (main + skid)
// buffer so that ready_o comes straight from a flop.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   flush_i              drop all held and incoming instructions
//   valid_i / ready_o    upstream handshake (ready_o registered)
//   instr_i, pc_i        instruction word and its PC
//   valid_o / ready_i    downstream handshake
//   pc_o                 PC of the decoded instruction
//   rs1/rs2/rd_addr_o    raw register index fields
//   alu_op_o, lsu_op_o, branch_op_o   operation selects
//   reg_write_o, alu_src_o, mem_write_o, mem_to_reg_o, is_jump_o, is_jalr_o
//   is_word_o            32-bit W-op, execute sign-extends result[31:0]
//   is_lui_o, is_auipc_o U-type selects
//   imm_o                sign-extended immediate
//   illegal_o            undecodable instruction

package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
    ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;

  typedef enum logic [2:0] {
    BRANCH_NONE, BRANCH_EQ, BRANCH_NE, BRANCH_LT, BRANCH_GE, BRANCH_LTU,
    BRANCH_GEU
  } branch_op_t;

endpackage

module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int ENABLE_M       = 1,
  parameter int ENABLE_ILLEGAL = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output alu_op_t         alu_op_o,
  output lsu_op_t         lsu_op_o,
  output branch_op_t      branch_op_o,
  output logic            reg_write_o,
  output logic            alu_src_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            is_jump_o,
  output logic            is_jalr_o,
  output logic            is_word_o,
  output logic            is_lui_o,
  output logic            is_auipc_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    alu_op_t         alu_op;
    lsu_op_t         lsu_op;
    branch_op_t      branch_op;
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            mem_to_reg;
    logic            is_jump;
    logic            is_jalr;
    logic            is_word;
    logic            is_lui;
    logic            is_auipc;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  function automatic alu_op_t alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t alu_m(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_rv64;
  logic        w_m_en;
  logic        w_shamt_hi;
  logic [63:0] w_imm_i;
  logic [63:0] w_imm_s;
  logic [63:0] w_imm_b;
  logic [63:0] w_imm_u;
  logic [63:0] w_imm_j;
  logic        w_ill;
  dec_t        w_dec;
  logic        w_in_fire;
  logic        w_out_fire;

  dec_t        r_main;
  dec_t        r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_rv64   = (XLEN == 64);
  assign w_m_en   = (ENABLE_M != 0);
  // On RV32 the shamt is only 5 bits, so instr[25] joins the must-be-zero field.
  assign w_shamt_hi = w_rv64 ? 1'b0 : instr_i[25];

  // Built at 64 bits and truncated to XLEN, so RV32 needs no special case.
  assign w_imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign w_imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
  assign w_imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

  always_comb begin
    w_ill         = 1'b0;
    w_dec         = '0;
    w_dec.pc      = pc_i;
    w_dec.rs1     = instr_i[19:15];
    w_dec.rs2     = instr_i[24:20];
    w_dec.rd      = instr_i[11:7];
    w_dec.alu_op    = ALU_ADD;
    w_dec.lsu_op    = LSU_NONE;
    w_dec.branch_op = BRANCH_NONE;
    case (w_opcode)
      OPC_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.is_lui    = 1'b1;
        w_dec.imm       = w_imm_u[XLEN-1:0];
      end
      OPC_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.is_auipc  = 1'b1;
        w_dec.imm       = w_imm_u[XLEN-1:0];
      end
      OPC_JAL: begin
        w_dec.reg_write = 1'b1;
        w_dec.is_jump   = 1'b1;
        w_dec.imm       = w_imm_j[XLEN-1:0];
      end
      OPC_JALR: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.is_jump   = 1'b1;
        w_dec.is_jalr   = 1'b1;
        w_dec.imm       = w_imm_i[XLEN-1:0];
      end
      OPC_BRANCH: begin
        w_dec.imm = w_imm_b[XLEN-1:0];
        case (w_funct3)
          3'b000:  w_dec.branch_op = BRANCH_EQ;
          3'b001:  w_dec.branch_op = BRANCH_NE;
          3'b100:  w_dec.branch_op = BRANCH_LT;
          3'b101:  w_dec.branch_op = BRANCH_GE;
          3'b110:  w_dec.branch_op = BRANCH_LTU;
          3'b111:  w_dec.branch_op = BRANCH_GEU;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.imm        = w_imm_i[XLEN-1:0];
        case (w_funct3)
          3'b000: w_dec.lsu_op = LSU_LB;
          3'b001: w_dec.lsu_op = LSU_LH;
          3'b010: w_dec.lsu_op = LSU_LW;
          3'b011: begin w_dec.lsu_op = LSU_LD;  w_ill = !w_rv64; end
          3'b100: w_dec.lsu_op = LSU_LBU;
          3'b101: w_dec.lsu_op = LSU_LHU;
          3'b110: begin w_dec.lsu_op = LSU_LWU; w_ill = !w_rv64; end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.imm       = w_imm_s[XLEN-1:0];
        case (w_funct3)
          3'b000: w_dec.lsu_op = LSU_SB;
          3'b001: w_dec.lsu_op = LSU_SH;
          3'b010: w_dec.lsu_op = LSU_SW;
          3'b011: begin w_dec.lsu_op = LSU_SD; w_ill = !w_rv64; end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.imm       = w_imm_i[XLEN-1:0];
        w_dec.alu_op    = alu_base(w_funct3, (w_funct3 == 3'b101) && instr_i[30]);
        if (w_funct3 == 3'b001)
          w_ill = (instr_i[31:26] != 6'b0) || w_shamt_hi;
        else if (w_funct3 == 3'b101)
          w_ill = instr_i[31] || (instr_i[29:26] != 4'b0) || w_shamt_hi;
      end
      OPC_OP_IMM32: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.is_word   = 1'b1;
        w_dec.imm       = w_imm_i[XLEN-1:0];
        w_dec.alu_op    = alu_base(w_funct3, (w_funct3 == 3'b101) && instr_i[30]);
        case (w_funct3)
          3'b000:  w_ill = 1'b0;
          3'b001:  w_ill = (w_funct7 != 7'b0);
          3'b101:  w_ill = instr_i[31] || (instr_i[29:25] != 5'b0);
          default: w_ill = 1'b1;
        endcase
        if (!w_rv64) w_ill = 1'b1;
      end
      OPC_OP: begin
        w_dec.reg_write = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          w_dec.alu_op = alu_m(w_funct3);
          w_ill        = !w_m_en;
        end else if (w_funct7 == 7'b0000000) begin
          w_dec.alu_op = alu_base(w_funct3, 1'b0);
        end else if (w_funct7 == 7'b0100000 &&
                     (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_dec.alu_op = alu_base(w_funct3, 1'b1);
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_32: begin
        w_dec.reg_write = 1'b1;
        w_dec.is_word   = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          w_dec.alu_op = alu_m(w_funct3);
          // Only MULW and the four divide/remainder ops have W forms.
          w_ill = !w_m_en || (w_funct3 inside {3'b001, 3'b010, 3'b011});
        end else if (w_funct7 == 7'b0000000 &&
                     (w_funct3 inside {3'b000, 3'b001, 3'b101})) begin
          w_dec.alu_op = alu_base(w_funct3, 1'b0);
        end else if (w_funct7 == 7'b0100000 &&
                     (w_funct3 inside {3'b000, 3'b101})) begin
          w_dec.alu_op = alu_base(w_funct3, 1'b1);
        end else begin
          w_ill = 1'b1;
        end
        if (!w_rv64) w_ill = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // Fences and system ops carry no datapath work in this stage.
      end
      default: w_ill = 1'b1;
    endcase

    // An illegal instruction travels down the pipe as a NOP with its fields
    // intact so the trap logic can still report PC, registers and immediate.
    if (w_ill) begin
      w_dec.alu_op     = ALU_ADD;
      w_dec.lsu_op     = LSU_NONE;
      w_dec.branch_op  = BRANCH_NONE;
      w_dec.reg_write  = 1'b0;
      w_dec.alu_src    = 1'b0;
      w_dec.mem_write  = 1'b0;
      w_dec.mem_to_reg = 1'b0;
      w_dec.is_jump    = 1'b0;
      w_dec.is_jalr    = 1'b0;
      w_dec.is_word    = 1'b0;
      w_dec.is_lui     = 1'b0;
      w_dec.is_auipc   = 1'b0;
    end
    w_dec.illegal = (ENABLE_ILLEGAL != 0) && w_ill;
  end

  assign ready_o    = !r_skid_valid;
  assign w_in_fire  = valid_i && ready_o;
  assign w_out_fire = r_main_valid && ready_i;

  // Main drains into execute; skid only fills while main is stalled, and it
  // empties back into main before any new input is accepted, keeping FIFO order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) r_main <= w_dec;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign valid_o      = r_main_valid;
  assign pc_o         = r_main.pc;
  assign rs1_addr_o   = r_main.rs1;
  assign rs2_addr_o   = r_main.rs2;
  assign rd_addr_o    = r_main.rd;
  assign alu_op_o     = r_main.alu_op;
  assign lsu_op_o     = r_main.lsu_op;
  assign branch_op_o  = r_main.branch_op;
  assign reg_write_o  = r_main.reg_write;
  assign alu_src_o    = r_main.alu_src;
  assign mem_write_o  = r_main.mem_write;
  assign mem_to_reg_o = r_main.mem_to_reg;
  assign is_jump_o    = r_main.is_jump;
  assign is_jalr_o    = r_main.is_jalr;
  assign is_word_o    = r_main.is_word;
  assign is_lui_o     = r_main.is_lui;
  assign is_auipc_o   = r_main.is_auipc;
  assign imm_o        = r_main.imm;
  assign illegal_o    = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of hand-decoded instructions applied back
// to back, plus directed sequences for backpressure, flush and async reset.
// Three instances share stimulus: RV64 with M, RV32 with M, RV64 without M.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;

  logic        ready_o, valid_o;
  logic [63:0] pc_o, imm_o;
  logic [4:0]  rs1, rs2, rd;
  alu_op_t     alu_op;
  lsu_op_t     lsu_op;
  branch_op_t  br_op;
  logic        rw, src, mw, m2r, jmp, jalr, word, lui, auipc, ill;

  logic        ready32, valid32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  alu_op_t     alu32;
  lsu_op_t     lsu32;
  branch_op_t  br32;
  logic        rw32, src32, mw32, m2r32, jmp32, jalr32, word32, lui32, auipc32, ill32;

  logic        readynm, validnm;
  logic [63:0] pcnm, immnm;
  logic [4:0]  rs1_nm, rs2_nm, rd_nm;
  alu_op_t     alunm;
  lsu_op_t     lsunm;
  branch_op_t  brnm;
  logic        rwnm, srcnm, mwnm, m2rnm, jmpnm, jalrnm, wordnm, luinm, auipcnm, illnm;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .ENABLE_M(1), .ENABLE_ILLEGAL(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_o),
    .instr_i(instr), .pc_i(pc), .valid_o(valid_o), .ready_i(ready_in), .pc_o(pc_o),
    .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd), .alu_op_o(alu_op),
    .lsu_op_o(lsu_op), .branch_op_o(br_op), .reg_write_o(rw), .alu_src_o(src),
    .mem_write_o(mw), .mem_to_reg_o(m2r), .is_jump_o(jmp), .is_jalr_o(jalr),
    .is_word_o(word), .is_lui_o(lui), .is_auipc_o(auipc), .imm_o(imm_o),
    .illegal_o(ill));

  decode_stage #(.XLEN(32), .ENABLE_M(1), .ENABLE_ILLEGAL(1)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready32),
    .instr_i(instr), .pc_i(pc[31:0]), .valid_o(valid32), .ready_i(ready_in), .pc_o(pc32),
    .rs1_addr_o(rs1_32), .rs2_addr_o(rs2_32), .rd_addr_o(rd_32), .alu_op_o(alu32),
    .lsu_op_o(lsu32), .branch_op_o(br32), .reg_write_o(rw32), .alu_src_o(src32),
    .mem_write_o(mw32), .mem_to_reg_o(m2r32), .is_jump_o(jmp32), .is_jalr_o(jalr32),
    .is_word_o(word32), .is_lui_o(lui32), .is_auipc_o(auipc32), .imm_o(imm32),
    .illegal_o(ill32));

  decode_stage #(.XLEN(64), .ENABLE_M(0), .ENABLE_ILLEGAL(1)) u_dutnm (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(readynm),
    .instr_i(instr), .pc_i(pc), .valid_o(validnm), .ready_i(ready_in), .pc_o(pcnm),
    .rs1_addr_o(rs1_nm), .rs2_addr_o(rs2_nm), .rd_addr_o(rd_nm), .alu_op_o(alunm),
    .lsu_op_o(lsunm), .branch_op_o(brnm), .reg_write_o(rwnm), .alu_src_o(srcnm),
    .mem_write_o(mwnm), .mem_to_reg_o(m2rnm), .is_jump_o(jmpnm), .is_jalr_o(jalrnm),
    .is_word_o(wordnm), .is_lui_o(luinm), .is_auipc_o(auipcnm), .imm_o(immnm),
    .illegal_o(illnm));

  // ctl = {reg_write, alu_src, mem_write, mem_to_reg, is_jump, is_jalr, is_word, is_lui, is_auipc}
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    alu_op_t     alu;
    lsu_op_t     lsu;
    branch_op_t  br;
    logic [8:0]  ctl;
    logic [63:0] imm;
    logic        ill, ill32, illnm;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b110000000, 64'd5,                 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h002081BB, 5'd3,  5'd1,  5'd2,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b100000100, 64'd0,                 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h027302B3, 5'd5,  5'd6,  5'd7,  ALU_MUL,  LSU_NONE, BRANCH_NONE, 9'b100000000, 64'd0,                 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'hFFFFF137, 5'd2,  5'd31, 5'd31, ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b110000010, 64'hFFFFFFFFFFFFF000,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h40C58533, 5'd10, 5'd11, 5'd12, ALU_SUB,  LSU_NONE, BRANCH_NONE, 9'b100000000, 64'd0,                 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h42115093, 5'd1,  5'd2,  5'd1,  ALU_SRA,  LSU_NONE, BRANCH_NONE, 9'b110000000, 64'h421,               1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'hFF833283, 5'd5,  5'd6,  5'd24, ALU_ADD,  LSU_LD,   BRANCH_NONE, 9'b110100000, 64'hFFFFFFFFFFFFFFF8,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h00743823, 5'd16, 5'd8,  5'd7,  ALU_ADD,  LSU_SD,   BRANCH_NONE, 9'b011000000, 64'd16,                1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'hFE208EE3, 5'd29, 5'd1,  5'd2,  ALU_ADD,  LSU_NONE, BRANCH_EQ,   9'b000000000, 64'hFFFFFFFFFFFFFFFC,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h001000EF, 5'd1,  5'd0,  5'd1,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b100010000, 64'h800,               1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00008067, 5'd0,  5'd1,  5'd0,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b110011000, 64'd0,                 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h12345217, 5'd4,  5'd8,  5'd3,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b110000001, 64'h12345000,          1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b000000000, 64'd0,                 1'b1, 1'b1, 1'b1};
    vecs[13] = '{32'h00002063, 5'd0,  5'd0,  5'd0,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b000000000, 64'd0,                 1'b1, 1'b1, 1'b1};
    vecs[14] = '{32'h04000033, 5'd0,  5'd0,  5'd0,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b000000000, 64'd0,                 1'b1, 1'b1, 1'b1};
    vecs[15] = '{32'h40009093, 5'd1,  5'd1,  5'd0,  ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b000000000, 64'h400,               1'b1, 1'b1, 1'b1};
    vecs[16] = '{32'h023150BB, 5'd1,  5'd2,  5'd3,  ALU_DIVU, LSU_NONE, BRANCH_NONE, 9'b100000100, 64'd0,                 1'b0, 1'b1, 1'b1};
    vecs[17] = '{32'hFFF10113, 5'd2,  5'd2,  5'd31, ALU_ADD,  LSU_NONE, BRANCH_NONE, 9'b110000000, 64'hFFFFFFFFFFFFFFFF,  1'b0, 1'b0, 1'b0};

    // Reset state
    step();
    step();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_alu", 64'(alu_op), 64'(ALU_ADD));
    chk("rst_imm", imm_o, 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_ready32", 64'(ready32), 64'd1);
    rst = 1'b0;
    ready_in = 1'b1;

    // Back-to-back stream, one per cycle, no bubbles
    for (int i = 0; i < 18; i++) begin
      instr    = vecs[i].instr;
      pc       = 64'h1000 + 64'(4 * i);
      valid_in = 1'b1;
      step();
      chk($sformatf("v%0d_valid", i), 64'(valid_o), 64'd1);
      chk($sformatf("v%0d_pc", i), pc_o, pc);
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 64'(rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 64'(rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_alu", i), 64'(alu_op), 64'(vecs[i].alu));
      chk($sformatf("v%0d_lsu", i), 64'(lsu_op), 64'(vecs[i].lsu));
      chk($sformatf("v%0d_br", i), 64'(br_op), 64'(vecs[i].br));
      chk($sformatf("v%0d_ctl", i), 64'({rw, src, mw, m2r, jmp, jalr, word, lui, auipc}),
          64'(vecs[i].ctl));
      chk($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
      chk($sformatf("v%0d_ill", i), 64'(ill), 64'(vecs[i].ill));
      chk($sformatf("v%0d_ill32", i), 64'(ill32), 64'(vecs[i].ill32));
      chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(vecs[i].imm[31:0]));
      chk($sformatf("v%0d_illnm", i), 64'(illnm), 64'(vecs[i].illnm));
      if (vecs[i].ill32) chk($sformatf("v%0d_rw32", i), 64'(rw32), 64'd0);
    end
    valid_in = 1'b0;
    step();
    chk("drain_valid", 64'(valid_o), 64'd0);

    // Backpressure: A to main, B to skid, C held off, then drained in order
    ready_in = 1'b0;
    valid_in = 1'b1;
    instr = vecs[0].instr;
    step();
    chk("bp_a_valid", 64'(valid_o), 64'd1);
    chk("bp_a_rd", 64'(rd), 64'd1);
    chk("bp_a_ready", 64'(ready_o), 64'd1);
    instr = vecs[4].instr;
    step();
    chk("bp_b_ready", 64'(ready_o), 64'd0);
    chk("bp_b_hold_rd", 64'(rd), 64'd1);
    instr = vecs[2].instr;
    step();
    chk("bp_c_ready", 64'(ready_o), 64'd0);
    chk("bp_c_hold_rd", 64'(rd), 64'd1);
    chk("bp_c_hold_imm", imm_o, 64'd5);
    ready_in = 1'b1;
    step();
    chk("bp_out_b_rd", 64'(rd), 64'd10);
    chk("bp_out_b_alu", 64'(alu_op), 64'(ALU_SUB));
    chk("bp_out_b_ready", 64'(ready_o), 64'd1);
    step();
    chk("bp_out_c_rd", 64'(rd), 64'd5);
    chk("bp_out_c_alu", 64'(alu_op), 64'(ALU_MUL));
    valid_in = 1'b0;
    step();
    chk("bp_end_valid", 64'(valid_o), 64'd0);

    // Flush with only main occupied and a new input offered
    ready_in = 1'b0;
    valid_in = 1'b1;
    instr = vecs[0].instr;
    step();
    instr = vecs[4].instr;
    flush = 1'b1;
    step();
    chk("fl1_valid", 64'(valid_o), 64'd0);
    chk("fl1_ready", 64'(ready_o), 64'd1);
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    chk("fl1_after_valid", 64'(valid_o), 64'd0);

    // Flush with main and skid full and an input offered
    ready_in = 1'b0;
    valid_in = 1'b1;
    instr = vecs[0].instr;
    step();
    instr = vecs[4].instr;
    step();
    chk("fl2_full_ready", 64'(ready_o), 64'd0);
    instr = vecs[2].instr;
    flush = 1'b1;
    step();
    chk("fl2_valid", 64'(valid_o), 64'd0);
    chk("fl2_ready", 64'(ready_o), 64'd1);
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl2_quiet%0d", k), 64'(valid_o), 64'd0);
    end

    // LUI on RV32 and asynchronous reset during a stall
    ready_in = 1'b0;
    valid_in = 1'b1;
    instr = vecs[3].instr;
    step();
    chk("lui_imm64", imm_o, 64'hFFFFFFFFFFFFF000);
    chk("lui_is_lui", 64'(lui), 64'd1);
    chk("lui_imm32", 64'(imm32), 64'hFFFFF000);
    instr = vecs[0].instr;
    step();
    valid_in = 1'b0;
    chk("ar_pre_ready", 64'(ready_o), 64'd0);
    chk("ar_pre_valid", 64'(valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(valid_o), 64'd0);
    chk("ar_ready", 64'(ready_o), 64'd1);
    chk("ar_imm", imm_o, 64'd0);
    #1;
    rst = 1'b0;
    ready_in = 1'b1;
    step();
    chk("ar_after_valid", 64'(valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
